buffer_request_arbiter: RTL and testbench
=========================================

Name: buffer_request_arbiter

Overview:
- Round-robin arbiter that shares one i_clk-domain write port of a dual-clock handshake buffer among NUM_PORTS requesters.
- Grants one requester at a time and holds the grant for a burst of up to MAX_BURST beats.
- Registers each accepted beat, tagged with the requester's ID, into a one-entry output stage that drives the buffer's valid/ready/data input.
- Sits entirely in the i_clk domain, upstream of the clock-crossing buffer.

Parameters:
- NUM_PORTS, 4, number of requesters (1..16).
- WIDTH, 8, data width per beat.
- MAX_BURST, 4, maximum beats accepted per grant (>=1).
- ID_WIDTH, max(1, clog2(NUM_PORTS)), derived; width of out_id and grant_id.

Ports:
- reset  in  1  asynchronous, active-high reset.
- i_clk  in  1  clock for all logic.
- in_valid  in  NUM_PORTS  per-requester beat valid.
- in_ready  out  NUM_PORTS  per-requester beat accepted when in_valid[p] && in_ready[p].
- in_data  in  NUM_PORTS*WIDTH  requester p data at bits [p*WIDTH +: WIDTH].
- out_valid  out  1  output beat valid; drives the buffer's i_valid.
- out_ready  in  1  from the buffer's i_ready.
- out_data  out  WIDTH  output beat data.
- out_id  out  ID_WIDTH  index of the requester that sourced out_data.
- grant_valid  out  1  high while in GRANT state.
- grant_id  out  ID_WIDTH  currently granted port; 0 when idle.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock i_clk. All state is registered on posedge i_clk.
- Reset values:
  - state=IDLE, ptr=0, grant_id=0, burst_cnt=0.
  - out_valid=0, out_data=0, out_id=0.
  - in_ready=0, grant_valid=0.
- Reset mid-burst discards any held output beat and clears the grant.
- States: IDLE, GRANT.
- IDLE:
  - If any in_valid bit is set, select the first port p with in_valid[p], searching from ptr upward and wrapping at NUM_PORTS-1 to 0.
  - Next edge: state=GRANT, grant_id=p, burst_cnt=0.
  - No beat is accepted in IDLE; in_ready is all zero.
- GRANT:
  - Output free: out_free = !out_valid || out_ready.
  - in_ready[grant_id] = out_free. All other in_ready bits are 0. in_ready is combinational.
  - Accept (in_valid[grant_id] && in_ready[grant_id]):
    - out_data <= in_data of the granted port, out_id <= grant_id, out_valid <= 1.
    - burst_cnt <= burst_cnt+1.
  - Release to IDLE at the next edge when either:
    - (a) an accept occurs with burst_cnt == MAX_BURST-1; or
    - (b) in_valid[grant_id] == 0.
  - On release: ptr <= (grant_id+1) mod NUM_PORTS, grant_id <= 0, burst_cnt <= 0.
  - If out_free is low while in_valid[grant_id] stays high: hold the grant; no release and no count change.
- Output stage:
  - If out_valid && out_ready with no new accept in the same cycle: out_valid <= 0.
  - Accept and drain in the same cycle: out_valid stays 1 and the new beat replaces the old one (full throughput).
  - out_data and out_id are stable while out_valid && !out_ready.
- Latency:
  - in_valid rising in cycle 0 with the arbiter in IDLE gives a grant at edge 1.
  - in_ready is high in cycle 1 if the output is free.
  - out_valid is high in cycle 2.
  - Within a burst, throughput is 1 beat/cycle when out_ready is held high.
- Re-arbitration costs exactly one IDLE cycle between grants, including when the same port requests again.
- Fairness: after port p's grant ends, every other port with in_valid held high is granted before p again.
- NUM_PORTS=1: ID_WIDTH=1, out_id is always 0, and ptr stays 0.
- MAX_BURST=1: exactly one beat per grant.
- burst_cnt width is clog2(MAX_BURST+1).
- Downstream i_ready may deassert for several cycles after each transfer. The arbiter must tolerate this by holding the beat and the grant, and must never drop or duplicate a beat.

Decomposition:
- Package buffer_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Function computing ID_WIDTH.
- Sub-module rr_pick (combinational):
  - Inputs: req[NUM_PORTS], ptr.
  - Outputs: any, sel[ID_WIDTH].
  - Uses a doubled-vector priority search.
- Top module holds the FSM, the counters and the output register.

Test Plan:
- Reset then idle: all in_valid=0 for 10 cycles -> in_ready=0, out_valid=0, grant_valid=0; reset asserted mid-burst -> out_valid=0 and state IDLE on the same cycle.
- Single port burst: port 2 valid with data 0x10..0x15 (6 beats), out_ready=1, MAX_BURST=4 -> out_data 0x10..0x13 with out_id=2 on 4 consecutive cycles, one idle gap, then 0x14,0x15.
- Round-robin: ports 0,1,3 always valid, one beat each (toggle in_valid after each beat) -> grant order 0,1,3,0,1,3; port 3 to port 0 wrap verified.
- Backpressure: port 1 granted, out_ready=0 for 5 cycles after the first beat -> out_data held at the first beat, in_ready[1]=0, no beat lost; after out_ready=1 the remaining beats arrive in order.
- Early release: port 0 drops in_valid after 2 of 4 beats while port 2 is valid -> port 0 releases, ptr=1, port 2 is granted next cycle.
- Dual-clock buffer in loop: arbiter connected to the real buffer with o_clk = 1.7 × i_clk period and random o_ready; 4 ports × 200 beats -> every beat is received exactly once, in per-port order, with the correct out_id.

Source files
------------

// File: rtl/buffer_request_arbiter_pkg.sv
// Shared types and helpers for the buffer request arbiter.
package buffer_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Port index width; a single requester still gets a 1-bit ID.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buffer_request_arbiter_if.sv
// Requester/output bundle between the requesters, the arbiter and the downstream buffer.
interface buffer_request_arbiter_if
    import buffer_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ID_WIDTH  = id_width(NUM_PORTS)
);

    logic [NUM_PORTS-1:0]       in_valid;
    logic [NUM_PORTS-1:0]       in_ready;
    logic [NUM_PORTS*WIDTH-1:0] in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [ID_WIDTH-1:0]        out_id;
    logic                       grant_valid;
    logic [ID_WIDTH-1:0]        grant_id;

    // Arbiter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id, grant_valid, grant_id
    );

    // Requesters plus downstream buffer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id, grant_valid, grant_id
    );

endinterface

// File: rtl/buffer_request_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_pick
    import buffer_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ID_WIDTH  = id_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  ptr,
    output logic                 any,
    output logic [ID_WIDTH-1:0]  sel
);

    localparam int unsigned IdxW = $clog2(2 * NUM_PORTS);

    logic [2*NUM_PORTS-1:0] req2;
    logic [IdxW-1:0]        idx;

    // Doubling the vector turns the wrap-around search into a linear one.
    assign req2 = {req, req};

    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = IdxW'(ptr) + IdxW'(i);
            if (!any && req2[idx]) begin
                any = 1'b1;
                sel = (idx >= IdxW'(NUM_PORTS)) ? ID_WIDTH'(idx - IdxW'(NUM_PORTS))
                                                : ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/buffer_request_arbiter.sv
// Round-robin burst arbiter feeding a one-entry output register into a dual-clock buffer.
module buffer_request_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic reset,
    input logic i_clk,
    buffer_request_arbiter_if.slave bus
);

    localparam int unsigned ID_WIDTH = id_width(NUM_PORTS);
    localparam int unsigned CntW     = $clog2(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [ID_WIDTH-1:0] out_id_q, out_id_d;

    logic                 pick_any;
    logic [ID_WIDTH-1:0]  pick_sel;
    logic                 gnt_valid;
    logic [WIDTH-1:0]     gnt_data;
    logic                 out_free;
    logic                 accept;
    logic [ID_WIDTH-1:0]  next_ptr;
    logic [NUM_PORTS-1:0] in_ready;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_rr_pick (
        .req (bus.in_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .sel (pick_sel)
    );

    // Mux the granted requester's valid and data.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_id_q == ID_WIDTH'(p)) begin
                gnt_valid = bus.in_valid[p];
                gnt_data  = bus.in_data[p*WIDTH +: WIDTH];
            end
        end
    end

    assign out_free = !out_valid_q || bus.out_ready;
    assign accept   = (state_q == StGrant) && gnt_valid && out_free;
    assign next_ptr = (grant_id_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        in_ready = '0;
        if (state_q == StGrant && out_free) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant_id_q == ID_WIDTH'(p)) in_ready[p] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d     = StGrant;
                    grant_id_d  = pick_sel;
                    burst_cnt_d = '0;
                end
            end
            StGrant: begin
                if (accept) burst_cnt_d = burst_cnt_q + CntW'(1);
                // Stalled output with the requester still valid keeps the grant untouched.
                if ((accept && burst_cnt_q == CntW'(MAX_BURST - 1)) || !gnt_valid) begin
                    state_d     = StIdle;
                    ptr_d       = next_ptr;
                    grant_id_d  = '0;
                    burst_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new beat may overwrite a beat that drains in the same cycle.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_id_d    = grant_id_q;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_id      = out_id_q;
    assign bus.grant_valid = (state_q == StGrant);
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_buffer_request_arbiter.sv
// Directed and randomised-stall bench for buffer_request_arbiter (4 ports, 8-bit, burst 4).
module tb_buffer_request_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 4;

    logic i_clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    buffer_request_arbiter_if #(.NUM_PORTS(NP), .WIDTH(W)) bus ();

    buffer_request_arbiter #(
        .NUM_PORTS (NP),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .reset (reset),
        .i_clk (i_clk),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic set_port(input int p, input logic v, input logic [W-1:0] d);
        bus.in_valid[p]       = v;
        bus.in_data[p*W +: W] = d;
    endtask

    // Leaves the bench just after a rising edge with the DUT idle and ptr at 0.
    task automatic apply_reset();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge i_clk);
        checks++;
        if (bus.out_data !== 8'h00 || bus.out_id !== 2'd0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: data=%h id=%0d gid=%0d, required 00/0/0",
                     bus.out_data, bus.out_id, bus.grant_id);
        end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge i_clk);
            checks++;
            if (bus.in_ready !== 4'b0 || bus.out_valid !== 1'b0 || bus.grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: in_ready=%b out_valid=%b grant_valid=%b, required 0",
                         c, bus.in_ready, bus.out_valid, bus.grant_valid);
            end
        end
        // Start a stalled burst on port 3, then reset while the beat is held.
        @(posedge i_clk); #1;
        set_port(3, 1'b1, 8'h77);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hold: valid=%b data=%h grant=%b, required 1/77/1",
                     bus.out_valid, bus.out_data, bus.grant_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.grant_valid !== 1'b0 || bus.in_ready !== 4'b0 ||
            dut.state_q !== buffer_arb_pkg::StIdle) begin
            errors++;
            $display("FAIL mid_burst_reset: valid=%b grant=%b in_ready=%b state=%0d, required 0/0/0/idle",
                     bus.out_valid, bus.grant_valid, bus.in_ready, dut.state_q);
        end
    endtask

    task automatic test_single_burst();
        bit         exp_ov [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        bit         exp_gv [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        logic [7:0] exp_d  [10] = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                                    8'h00, 8'h14, 8'h15, 8'h00};
        int   sent = 0;
        logic acc;
        apply_reset();
        set_port(2, 1'b1, 8'h10);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            checks++;
            if (bus.out_valid !== exp_ov[c] || bus.grant_valid !== exp_gv[c]) begin
                errors++;
                $display("FAIL burst_ctrl_c%0d: out_valid=%b grant_valid=%b, required %b/%b",
                         c, bus.out_valid, bus.grant_valid, exp_ov[c], exp_gv[c]);
            end
            if (exp_ov[c]) begin
                checks++;
                if (bus.out_data !== exp_d[c] || bus.out_id !== 2'd2) begin
                    errors++;
                    $display("FAIL burst_data_c%0d: data=%h id=%0d, required %h/2",
                             c, bus.out_data, bus.out_id, exp_d[c]);
                end
            end
            acc = bus.in_ready[2] && bus.in_valid[2];
            @(posedge i_clk); #1;
            if (acc) begin
                sent++;
                if (sent < 6) set_port(2, 1'b1, 8'h10 + 8'(sent));
                else set_port(2, 1'b0, 8'h00);
            end
        end
    endtask

    task automatic test_round_robin();
        int         act [3]   = '{0, 1, 3};
        int         exp_g [6] = '{0, 1, 3, 0, 1, 3};
        int         nbeat [4] = '{0, 0, 0, 0};
        logic [3:0] acc;
        logic       prev_gv = 1'b0;
        int         gq [$];
        int         iq [$];
        logic [7:0] dq [$];
        apply_reset();
        foreach (act[k]) set_port(act[k], 1'b1, 8'(act[k] * 16));
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (bus.grant_valid && !prev_gv) gq.push_back(int'(bus.grant_id));
            prev_gv = bus.grant_valid;
            if (bus.out_valid && bus.out_ready) begin
                iq.push_back(int'(bus.out_id));
                dq.push_back(bus.out_data);
            end
            acc = bus.in_ready & bus.in_valid;
            @(posedge i_clk); #1;
            foreach (act[k]) begin
                if (acc[act[k]]) begin
                    nbeat[act[k]]++;
                    set_port(act[k], 1'b0, 8'(act[k] * 16 + nbeat[act[k]]));
                end else if (nbeat[act[k]] < 2) begin
                    bus.in_valid[act[k]] = 1'b1;
                end
            end
        end
        checks++;
        if (gq.size() != 6 || iq.size() != 6) begin
            errors++;
            $display("FAIL rr_counts: grants=%0d beats=%0d, required 6/6", gq.size(), iq.size());
        end
        for (int i = 0; i < 6 && i < gq.size() && i < iq.size(); i++) begin
            checks++;
            if (gq[i] != exp_g[i] || iq[i] != exp_g[i] ||
                dq[i] !== 8'(exp_g[i] * 16 + i / 3)) begin
                errors++;
                $display("FAIL rr_order%0d: grant=%0d id=%0d data=%h, required %0d/%0d/%h",
                         i, gq[i], iq[i], dq[i], exp_g[i], exp_g[i], 8'(exp_g[i] * 16 + i / 3));
            end
        end
    endtask

    task automatic test_backpressure();
        int         n = 0;
        logic       acc;
        logic [7:0] dq [$];
        int         iq [$];
        apply_reset();
        set_port(1, 1'b1, 8'hA0);
        for (int c = 0; c < 14; c++) begin
            @(negedge i_clk);
            if (c >= 2 && c <= 6) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0 || bus.in_ready !== 4'b0 ||
                    bus.grant_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold_c%0d: valid=%b data=%h in_ready=%b grant=%b, required 1/a0/0000/1",
                             c, bus.out_valid, bus.out_data, bus.in_ready, bus.grant_valid);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                dq.push_back(bus.out_data);
                iq.push_back(int'(bus.out_id));
            end
            acc = bus.in_ready[1] && bus.in_valid[1];
            @(posedge i_clk); #1;
            bus.out_ready = !((c + 1) >= 2 && (c + 1) <= 6);
            if (acc) begin
                n++;
                if (n < 4) set_port(1, 1'b1, 8'hA0 + 8'(n));
                else set_port(1, 1'b0, 8'h00);
            end
        end
        checks++;
        if (dq.size() != 4) begin
            errors++;
            $display("FAIL bp_count: beats=%0d, required 4", dq.size());
        end
        for (int i = 0; i < dq.size() && i < 4; i++) begin
            checks++;
            if (dq[i] !== 8'hA0 + 8'(i) || iq[i] != 1) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h id=%0d, required %h/1", i, dq[i], iq[i],
                         8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_early_release();
        int   n = 0;
        logic acc;
        apply_reset();
        set_port(0, 1'b1, 8'hB0);
        set_port(2, 1'b1, 8'hC0);
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (c == 3) begin
                checks++;
                if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
                    errors++;
                    $display("FAIL early_c3: grant=%b gid=%0d, required 1/0",
                             bus.grant_valid, bus.grant_id);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0 || dut.ptr_q !== 2'd1) begin
                    errors++;
                    $display("FAIL early_c4: grant=%b gid=%0d ptr=%0d, required 0/0/1",
                             bus.grant_valid, bus.grant_id, dut.ptr_q);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2 || bus.in_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL early_c5: grant=%b gid=%0d in_ready=%b, required 1/2/0100",
                             bus.grant_valid, bus.grant_id, bus.in_ready);
                end
            end
            acc = bus.in_ready[0] && bus.in_valid[0];
            @(posedge i_clk); #1;
            if (acc) begin
                n++;
                if (n < 2) set_port(0, 1'b1, 8'hB0 + 8'(n));
                else set_port(0, 1'b0, 8'h00);
            end
        end
        bus.in_valid = '0;
    endtask

    task automatic test_random_stall();
        localparam int Beats = 40;
        int         sent [4] = '{0, 0, 0, 0};
        int         recv [4] = '{0, 0, 0, 0};
        logic [3:0] acc;
        logic       prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        logic [1:0] prev_id = '0;
        int         cyc = 0;
        apply_reset();
        for (int p = 0; p < 4; p++) set_port(p, 1'b1, {2'(p), 6'd0});
        while ((recv[0] + recv[1] + recv[2] + recv[3]) < 4 * Beats && cyc < 6000) begin
            @(negedge i_clk);
            cyc++;
            if (prev_hold) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_id !== prev_id) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b data=%h id=%0d, required 1/%h/%0d",
                             bus.out_valid, bus.out_data, bus.out_id, prev_data, prev_id);
                end
            end
            if ($countones(bus.in_ready) > 1) begin
                errors++;
                $display("FAIL ready_onehot: in_ready=%b, required at most one bit", bus.in_ready);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_id !== bus.out_data[7:6] ||
                    int'(bus.out_data[5:0]) != recv[bus.out_id]) begin
                    errors++;
                    $display("FAIL stream_beat: id=%0d data=%h, required id=%0d seq=%0d",
                             bus.out_id, bus.out_data, bus.out_data[7:6], recv[bus.out_data[7:6]]);
                end
                recv[bus.out_data[7:6]]++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_id   = bus.out_id;
            acc = bus.in_ready & bus.in_valid;
            @(posedge i_clk); #1;
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) sent[p]++;
                set_port(p, (sent[p] < Beats) && ($urandom_range(0, 3) != 0),
                         {2'(p), 6'(sent[p])});
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (recv[p] != Beats || sent[p] != Beats) begin
                errors++;
                $display("FAIL stream_total_p%0d: received=%0d sent=%0d, required %0d",
                         p, recv[p], sent[p], Beats);
            end
        end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
